// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo_sync write port among NREQ producers.
// Grants bursts of up to MAX_BURST beats; forwards beats only while not full.
module fifo_wr_arbiter #(
    parameter  int NREQ      = 4,
    parameter  int WIDTH     = 8,
    parameter  int MAX_BURST = 4,
    localparam int IW        = $clog2(NREQ),
    localparam int BW        = $clog2(MAX_BURST + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       i_req_valid,
    input  logic [NREQ-1:0]       i_req_last,
    input  logic [NREQ*WIDTH-1:0] i_req_data,
    output logic [NREQ-1:0]       o_req_ready,
    input  logic                  i_fifo_full,
    output logic                  o_fifo_wr_en,
    output logic [WIDTH-1:0]      o_fifo_wr_data,
    output logic [IW-1:0]         o_grant_id,
    output logic                  o_busy
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          r_state, w_state_nx;
    logic [IW-1:0]   r_owner, w_owner_nx;
    logic [IW-1:0]   r_last_grant, w_last_grant_nx;
    logic [BW-1:0]   r_beats, w_beats_nx;
    logic [IW-1:0]   w_sel;
    logic            w_found;
    int              w_idx;
    logic            w_valid;
    logic            w_last;
    logic [WIDTH-1:0] w_data;
    logic            w_xfer;
    logic            w_release;

    // First requester after last_grant, wrapping modulo NREQ
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = (int'(r_last_grant) + k) % NREQ;
            if (!w_found && i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_sel   = IW'(w_idx);
            end
        end
    end

    always_comb begin
        w_valid = 1'b0;
        w_last  = 1'b0;
        w_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == IW'(i)) begin
                w_valid = i_req_valid[i];
                w_last  = i_req_last[i];
                w_data  = i_req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_owner_nx      = r_owner;
        w_last_grant_nx = r_last_grant;
        w_beats_nx      = r_beats;
        w_xfer          = 1'b0;
        w_release       = 1'b0;
        o_fifo_wr_en    = 1'b0;
        o_fifo_wr_data  = '0;
        o_req_ready     = '0;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nx      = BURST;
                    w_owner_nx      = w_sel;
                    w_last_grant_nx = w_sel;
                    w_beats_nx      = '0;
                end
            end
            BURST: begin
                w_xfer    = w_valid && !i_fifo_full;
                w_release = w_xfer &&
                            (w_last || (r_beats + 1'b1) == BW'(MAX_BURST));
                o_fifo_wr_en         = w_xfer;
                o_fifo_wr_data       = w_data;
                o_req_ready[r_owner] = !i_fifo_full;
                if (w_xfer)
                    w_beats_nx = r_beats + 1'b1;
                if (w_release)
                    w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_last_grant <= IW'(NREQ - 1);
            r_beats      <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_owner      <= w_owner_nx;
            r_last_grant <= w_last_grant_nx;
            r_beats      <= w_beats_nx;
        end
    end

    assign o_busy     = (r_state == BURST);
    assign o_grant_id = r_owner;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, WIDTH=8, MAX_BURST=4).
// Stimulus applied 1 time unit after each rising edge, checked 1 unit later.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic [3:0]  ready;
    logic        full;
    logic        wr_en;
    logic [7:0]  wdata;
    logic [1:0]  gid;
    logic        busy;

    int n_chk;
    int n_pass;

    fifo_wr_arbiter #(
        .NREQ      (4),
        .WIDTH     (8),
        .MAX_BURST (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req_valid    (valid),
        .i_req_last     (last),
        .i_req_data     (data),
        .o_req_ready    (ready),
        .i_fifo_full    (full),
        .o_fifo_wr_en   (wr_en),
        .o_fifo_wr_data (wdata),
        .o_grant_id     (gid),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = '0;
        last  = '0;
        full  = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  busy,  0);
        chk({tag, "_wren"},  wr_en, 0);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_gid"},   gid,   0);
        chk({tag, "_data"},  wdata, 0);
    endtask

    int pat[17] = '{-1, 2, 2, 2, 2, -1, 1, -1, 2, 2, 2, 2, -1, 1, -1, 2, 2};
    int d2;
    int p;
    int wi;
    logic [5:0] seq[4];
    int hs;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        valid  = '0;
        last   = '0;
        data   = '0;
        full   = 1'b0;
        cyc();
        do_reset();
        #1;
        chk_zero("rst");

        // single producer, three beats
        valid = 4'b0001;
        data  = 32'h11;
        #1;
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_wren", wr_en, 0);
        for (int b = 0; b < 3; b++) begin
            cyc();
            data = 32'(8'h11 + b);
            last = (b == 2) ? 4'b0001 : 4'b0000;
            #1;
            chk("t1_wren", wr_en, 1);
            chk("t1_data", wdata, 8'h11 + b);
            chk("t1_gid", gid, 0);
        end
        cyc();
        valid = '0;
        last  = '0;
        #1;
        chk("t1_done", busy, 0);

        // all four valid, single-beat packets
        do_reset();
        valid = 4'b1111;
        last  = 4'b1111;
        data  = 32'hA3A2A1A0;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t2_idle", busy, 0);
            cyc();
            chk("t2_wren", wr_en, 1);
            chk("t2_gid", gid, k % 4);
            chk("t2_data", wdata, 8'hA0 + (k % 4));
            cyc();
        end

        // producer 2 streams 10 beats, producer 1 interleaves
        d2 = 0;
        for (int c = 0; c < 17; c++) begin
            valid = {1'b0, (d2 < 10), 2'b10};
            last  = 4'b0010;
            data  = {8'h00, 8'(8'h20 + d2), 8'h55, 8'h00};
            #1;
            if (pat[c] < 0) begin
                chk("t3_idle", busy, 0);
            end else begin
                chk("t3_wren", wr_en, 1);
                chk("t3_gid", gid, pat[c]);
                chk("t3_data", wdata, (pat[c] == 2) ? 8'h20 + d2 : 8'h55);
            end
            if (ready[2] && valid[2])
                d2++;
            cyc();
        end
        valid = 4'b0010;
        #1;
        chk("t3_stall_busy", busy, 1);
        chk("t3_stall_wren", wr_en, 0);
        chk("t3_stall_gid", gid, 2);
        chk("t3_beats", d2, 10);

        // full raised on 2nd beat for 3 cycles
        do_reset();
        p  = 0;
        wi = 0;
        for (int c = 0; c < 9; c++) begin
            valid = {3'b000, (p < 4)};
            last  = {3'b000, (p == 3)};
            data  = 32'(8'h40 + p);
            full  = (c >= 2 && c <= 4);
            #1;
            if (full) begin
                chk("t4_full_wren", wr_en, 0);
                chk("t4_full_ready", ready, 0);
                chk("t4_full_busy", busy, 1);
            end
            if (wr_en) begin
                chk("t4_sb_data", wdata, 8'h40 + wi);
                wi++;
            end
            if (ready[0] && valid[0])
                p++;
            cyc();
        end
        full = 1'b0;
        #1;
        chk("t4_count", wi, 4);
        chk("t4_done", busy, 0);

        // reset mid-burst of requester 3
        do_reset();
        valid = 4'b1000;
        data  = 32'h30000000;
        #1;
        chk("t5_idle", busy, 0);
        cyc();
        chk("t5_gid", gid, 3);
        chk("t5_wren", wr_en, 1);
        cyc();
        data = 32'h31000000;
        #1;
        chk("t5_wren2", wr_en, 1);
        cyc();
        rst_n = 1'b0;
        valid = 4'b1001;
        data  = 32'h32000001;
        cyc();
        rst_n = 1'b1;
        #1;
        chk_zero("t5_rst");
        cyc();
        chk("t5_regrant_busy", busy, 1);
        chk("t5_regrant_gid", gid, 0);

        // randomized valid/last/full
        do_reset();
        for (int i = 0; i < 4; i++)
            seq[i] = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 4; i++) begin
                valid[i] = ($urandom_range(3) != 0);
                last[i]  = ($urandom_range(2) == 0);
                data[i*8 +: 8] = {2'(i), seq[i]};
            end
            full = ($urandom_range(3) == 0);
            #1;
            chk("r_wr_full", wr_en && full, 0);
            chk("r_onehot", $countones(ready) <= 1, 1);
            hs = -1;
            for (int i = 0; i < 4; i++)
                if (ready[i] && valid[i])
                    hs = i;
            chk("r_wren", wr_en, hs >= 0);
            if (hs >= 0) begin
                chk("r_order", wdata, {2'(hs), seq[hs]});
                seq[hs] = seq[hs] + 1'b1;
            end
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
